// File: rtl/cordic_fm_demod.sv
// cordic_fm_demod: CORDIC sequencer + FM phase-difference discriminator with DECIM averaging and output FIFO; CORDIC_FM_DEMOD_TIMEOUT_EN enables the WAIT watchdog.
module cordic_fm_demod #(
  parameter int DECIM = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [7:0]               s_i,
  input  logic [7:0]               s_q,
  output logic                     cor_start,
  output logic [7:0]               cor_x,
  output logic [7:0]               cor_y,
  input  logic [15:0]              cor_angle,
  input  logic                     cor_done,
  input  logic                     cor_ready,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [15:0]              m_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     timeout
);
  localparam int LD = $clog2(DECIM);
  localparam int LA = $clog2(DEPTH);
  localparam int SW = 16 + LD;
  typedef enum logic [1:0] {IDLE, WAIT, ACC} state_t;
  state_t state_q;
  logic [15:0] ang_q, prev_q;
  logic have_prev_q;
  logic signed [SW-1:0] sum_q, sum_d, diff_x;
  logic [LD:0] cnt_q, cnt_d;
  logic signed [15:0] diff;
  logic [15:0] avg;
  logic [15:0] mem_q [DEPTH];
  logic [LA-1:0] wr_q, rd_q;
  logic [LA:0] count_q;
  logic push, pop, wr_ok, wd_exp;
  // Native 16-bit wrap makes the phase difference correct across the +/-pi seam.
  assign diff = ang_q - prev_q;
  assign diff_x = diff;
  assign sum_d = sum_q + diff_x;
  assign cnt_d = cnt_q + 1'b1;
  assign avg = 16'(sum_d >>> LD);
  assign push = state_q == ACC && have_prev_q && cnt_d == (LD+1)'(DECIM);
  assign pop = m_valid && m_ready;
  assign wr_ok = push && (count_q != (LA+1)'(DEPTH) || pop);
  assign s_ready = state_q == IDLE && cor_ready;
  assign m_valid = count_q != '0;
  assign m_data = m_valid ? mem_q[rd_q] : 16'h0000;
  assign count = count_q;
`ifdef CORDIC_FM_DEMOD_TIMEOUT_EN
  logic [5:0] wd_q;
  assign wd_exp = state_q == WAIT && !cor_done && &wd_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
      timeout <= 1'b0;
    end else begin
      wd_q <= state_q == WAIT ? wd_q + 1'b1 : 6'd0;
      if (wd_exp) timeout <= 1'b1;
    end
  end
`else
  assign wd_exp = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cor_start <= 1'b0;
      cor_x <= '0;
      cor_y <= '0;
      ang_q <= '0;
      prev_q <= '0;
      have_prev_q <= 1'b0;
      sum_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      overflow <= 1'b0;
    end else begin
      cor_start <= 1'b0;
      case (state_q)
        IDLE: if (s_valid && s_ready) begin
          cor_x <= s_i;
          cor_y <= s_q;
          cor_start <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: if (cor_done) begin
          ang_q <= cor_angle;
          state_q <= ACC;
        end else if (wd_exp) state_q <= IDLE;
        ACC: begin
          state_q <= IDLE;
          prev_q <= ang_q;
          have_prev_q <= 1'b1;
          if (have_prev_q) begin
            sum_q <= push ? '0 : sum_d;
            cnt_q <= push ? '0 : cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (wr_ok) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !wr_ok) overflow <= 1'b1;
      count_q <= count_q + (LA+1)'(wr_ok) - (LA+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (wr_ok) mem_q[wr_q] <= avg;
endmodule

// File: tb/tb_cordic_fm_demod.sv
// tb_cordic_fm_demod: randomized check of cordic_fm_demod against a floor-average phase-difference model.
module tb_cordic_fm_demod;
  localparam int DECIM = 4;
  localparam int DEPTH = 16;
  logic clk = 0, reset = 1, s_valid = 0, cor_done = 0, cor_ready = 1, m_ready = 0;
  logic [7:0] s_i = 0, s_q = 0;
  logic [15:0] cor_angle = 0;
  logic s_ready, cor_start, m_valid, overflow, timeout;
  logic [7:0] cor_x, cor_y;
  logic [15:0] m_data;
  logic [$clog2(DEPTH):0] count;
  cordic_fm_demod #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q),
    .cor_start(cor_start), .cor_x(cor_x), .cor_y(cor_y), .cor_angle(cor_angle),
    .cor_done(cor_done), .cor_ready(cor_ready), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .count(count), .overflow(overflow), .timeout(timeout)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  int m_have, m_prev, m_sum, m_cnt;
  bit m_ovf;
  int q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int wrap16(input int v);
    int w;
    w = v & 32'hFFFF;
    return w >= 32768 ? w - 65536 : w;
  endfunction
  task automatic model_clear();
    m_have = 0; m_prev = 0; m_sum = 0; m_cnt = 0; m_ovf = 0;
    q.delete();
  endtask
  task automatic model_feed(input int a);
    int avg;
    if (!m_have) begin
      m_have = 1;
      m_prev = a;
    end else begin
      m_sum += wrap16(a - m_prev);
      m_prev = a;
      m_cnt++;
      if (m_cnt == DECIM) begin
        avg = m_sum >= 0 ? m_sum / DECIM : -((-m_sum + DECIM - 1) / DECIM);
        if (q.size() < DEPTH) q.push_back(avg & 32'hFFFF);
        else m_ovf = 1;
        m_sum = 0;
        m_cnt = 0;
      end
    end
  endtask
  task automatic do_reset();
    reset = 1; s_valid = 0; cor_done = 0; m_ready = 0; cor_ready = 1;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
  endtask
  task automatic accept(output logic [7:0] si, output logic [7:0] sq);
    int t = 0;
    while (!s_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("s_ready_wait", 0, 1);
    si = 8'($urandom); sq = 8'($urandom);
    s_i = si; s_q = sq; s_valid = 1;
    @(posedge clk); #1;
    s_valid = 0;
  endtask
  task automatic send(input logic [15:0] ang);
    logic [7:0] si, sq;
    int lat;
    lat = $urandom_range(0, 3);
    accept(si, sq);
    chk("cor_start", cor_start, 1);
    chk("cor_x", cor_x, si);
    chk("cor_y", cor_y, sq);
    chk("s_ready_busy", s_ready, 0);
    repeat (lat) begin
      @(posedge clk); #1;
    end
    cor_angle = ang; cor_done = 1;
    @(posedge clk); #1;
    cor_done = 0;
    chk("start_pulse", cor_start, 0);
    @(posedge clk); #1;
    model_feed(ang);
    chk("count", count, q.size());
    chk("m_valid", m_valid, q.size() != 0);
    chk("overflow", overflow, m_ovf);
    chk("s_ready_idle", s_ready, 1);
  endtask
  task automatic pop_one();
    chk("m_data", m_data, q[0]);
    void'(q.pop_front());
    m_ready = 1;
    @(posedge clk); #1;
    m_ready = 0;
    chk("count_pop", count, q.size());
  endtask
  task automatic drain();
    while (q.size() > 0) pop_one();
    chk("empty", m_valid, 0);
  endtask
  initial begin
    logic [7:0] si, sq;
    model_clear();
    @(posedge clk); #1;
    chk("rst_start", cor_start, 0);
    chk("rst_x", cor_x, 0);
    chk("rst_y", cor_y, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tmo", timeout, 0);
    reset = 0;
    #1 chk("rst_sready", s_ready, 1);
    repeat (5) send(16'h1000);
    chk("const_count", count, 1);
    chk("const_data", m_data, 16'h0000);
    drain();
    do_reset();
    for (int i = 0; i < 5; i++) send(16'(i * 16'h0400));
    chk("ramp_up", m_data, 16'h0400);
    drain();
    do_reset();
    for (int i = 0; i < 5; i++) send(16'(-(i * 16'h0400)));
    chk("ramp_down", m_data, 16'hFC00);
    drain();
    do_reset();
    for (int i = 0; i < 5; i++) send(16'(16'h7B00 + i * 16'h0200));
    chk("wrap", m_data, 16'h0200);
    drain();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) pop_one();
    end
    drain();
    do_reset();
    for (int i = 0; i < 1 + 17 * DECIM; i++) send(16'($urandom));
    chk("full_count", count, DEPTH);
    chk("full_ovf", overflow, 1);
    drain();
    cor_ready = 0;
    #1 chk("sready_corbusy", s_ready, 0);
    s_valid = 1;
    @(posedge clk); #1;
    s_valid = 0;
    chk("no_start_corbusy", cor_start, 0);
    cor_ready = 1;
    do_reset();
    send(16'h2000);
    send(16'h2400);
    accept(si, sq);
    chk("wait_start", cor_start, 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    chk("rstw_start", cor_start, 0);
    chk("rstw_idle", s_ready, 1);
    cor_angle = 16'h7777; cor_done = 1;
    @(posedge clk); #1;
    cor_done = 0;
    @(posedge clk); #1;
    chk("late_done_mv", m_valid, 0);
    chk("late_done_idle", s_ready, 1);
    for (int i = 0; i < 4; i++) send(16'(16'h1000 + i * 16'h0100));
    chk("rstw_4", count, 0);
    send(16'h1400);
    chk("rstw_5", count, 1);
    chk("rstw_data", m_data, 16'h0100);
    drain();
    accept(si, sq);
    repeat (66) @(posedge clk);
    #1;
`ifdef CORDIC_FM_DEMOD_TIMEOUT_EN
    chk("tmo_flag", timeout, 1);
    chk("tmo_idle", s_ready, 1);
`else
    chk("tmo_flag", timeout, 0);
    chk("tmo_stuck", s_ready, 0);
`endif
    do_reset();
    chk("tmo_rst", timeout, 0);
    chk("tmo_rst_idle", s_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
